// File: rtl/pwm_meter_pkg.sv
// Shared state encoding and arithmetic helpers for the pwm_meter block.
// Latency: none, this file holds only types and pure functions.
// Backpressure: none.
package pwm_meter_pkg;

  // Per-channel measurement FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } ch_state_t;

  // Bits needed to hold a prescaler count of 0..presc-1 (never below 1)
  function automatic int presc_width(input int presc);
    return (presc <= 2) ? 1 : $clog2(presc);
  endfunction

  // Increment that sticks at the all-ones value of a 'width'-bit field
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int width);
    logic [63:0] max_v;
    max_v = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (val == max_v) ? val : val + 64'd1;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One measurement engine: synchroniser, phase FSM, saturating accumulators, results, sticky rdy.
// Latency: a cnt edge sampled at edge k is captured (results and rdy) at edge k+SYNC_STAGES.
// Backpressure: none; rdy is sticky until ack, and a new capture overwrites unread results.
module pwm_channel
  import pwm_meter_pkg::*;
#(
  parameter int WIDTH       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnt,
  input  logic             en,
  input  logic             ack,
  input  logic             tick,
  output logic [WIDTH-1:0] res_p,
  output logic [WIDTH-1:0] res_m,
  output logic             res_ovf_p,
  output logic             res_ovf_m,
  output logic             rdy
);

  localparam logic [WIDTH-1:0] ACC_MAX = {WIDTH{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   lvl;
  logic                   rise;
  logic                   fall;

  ch_state_t        state;
  logic [WIDTH-1:0] p_acc;
  logic [WIDTH-1:0] m_acc;
  logic             sat_p;
  logic             sat_m;
  logic [WIDTH-1:0] p_inc;
  logic [WIDTH-1:0] m_inc;
  logic [WIDTH-1:0] fresh;

  assign lvl  = sync_q[SYNC_STAGES-1];
  assign rise = lvl & ~hist_q;
  assign fall = ~lvl & hist_q;

  assign p_inc = WIDTH'(sat_inc(64'(p_acc), WIDTH));
  assign m_inc = WIDTH'(sat_inc(64'(m_acc), WIDTH));
  // A phase entered on a tick cycle already owns that tick
  assign fresh = WIDTH'(tick);

  // Bring the asynchronous input into clk and keep one cycle of history for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cnt};
      hist_q <= lvl;
    end
  end

  // Phase FSM: accumulate high/low ticks, capture on the closing edge, flag each full period
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      p_acc     <= '0;
      m_acc     <= '0;
      sat_p     <= 1'b0;
      sat_m     <= 1'b0;
      res_p     <= '0;
      res_m     <= '0;
      res_ovf_p <= 1'b0;
      res_ovf_m <= 1'b0;
      rdy       <= 1'b0;
    end else begin
      // A capture later in this block overrides the clear
      if (ack) rdy <= 1'b0;
      if (!en) begin
        state <= ST_IDLE;
        p_acc <= '0;
        m_acc <= '0;
        sat_p <= 1'b0;
        sat_m <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_ARM;
          ST_ARM: begin
            // The phase in progress at enable time is partial, so wait for a clean rise
            if (rise) begin
              p_acc <= fresh;
              sat_p <= 1'b0;
              state <= ST_HIGH;
            end
          end
          ST_HIGH: begin
            if (fall) begin
              res_p     <= p_acc;
              res_ovf_p <= sat_p;
              m_acc     <= fresh;
              sat_m     <= 1'b0;
              state     <= ST_LOW;
            end else if (tick) begin
              p_acc <= p_inc;
              if (p_acc == ACC_MAX) sat_p <= 1'b1;
            end
          end
          ST_LOW: begin
            if (rise) begin
              res_m     <= m_acc;
              res_ovf_m <= sat_m;
              p_acc     <= fresh;
              sat_p     <= 1'b0;
              rdy       <= 1'b1;
              state     <= ST_HIGH;
            end else if (tick) begin
              m_acc <= m_inc;
              if (m_acc == ACC_MAX) sat_m <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/pwm_meter.sv
// Multi-channel pulse-width meter with shared prescaler and registered channel-select readout; PWM_PERIOD_EN adds the period port.
// Latency: readout (count_p/count_m/ovf/period) lags the channel results and sel by 1 clk.
// Backpressure: none; per-channel rdy stays set until ack, new captures overwrite results.
module pwm_meter
  import pwm_meter_pkg::*;
#(
  parameter int  CH          = 2,
  parameter int  WIDTH       = 24,
  parameter int  PRESCALE    = 3,
  parameter int  SYNC_STAGES = 2,
  localparam int SEL_W       = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CH-1:0]    cnt,
  input  logic [CH-1:0]    en,
  input  logic [SEL_W-1:0] sel,
  input  logic [CH-1:0]    ack,
  output logic [WIDTH-1:0] count_p,
  output logic [WIDTH-1:0] count_m,
  output logic             ovf,
  output logic [CH-1:0]    rdy
`ifdef PWM_PERIOD_EN
  ,
  output logic [WIDTH:0]   period
`endif
);

  localparam int              PS_W   = presc_width(PRESCALE);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]  ps_q;
  logic             tick;
  logic [WIDTH-1:0] res_p [CH];
  logic [WIDTH-1:0] res_m [CH];
  logic [CH-1:0]    ovf_p;
  logic [CH-1:0]    ovf_m;

  assign tick = (ps_q == PS_MAX);

  // Free-running prescaler shared by every channel, independent of en
  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q <= '0;
    end else if (tick) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_q + PS_W'(1);
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    pwm_channel #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .cnt       (cnt[i]),
      .en        (en[i]),
      .ack       (ack[i]),
      .tick      (tick),
      .res_p     (res_p[i]),
      .res_m     (res_m[i]),
      .res_ovf_p (ovf_p[i]),
      .res_ovf_m (ovf_m[i]),
      .rdy       (rdy[i])
    );
  end

  // Registered readout of the selected channel; unpopulated select codes read as zero
  always_ff @(posedge clk) begin
    if (reset) begin
      count_p <= '0;
      count_m <= '0;
      ovf     <= 1'b0;
    end else if (int'(sel) < CH) begin
      count_p <= res_p[sel];
      count_m <= res_m[sel];
      ovf     <= ovf_p[sel] | ovf_m[sel];
    end else begin
      count_p <= '0;
      count_m <= '0;
      ovf     <= 1'b0;
    end
  end

`ifdef PWM_PERIOD_EN
  // Full period of the selected channel, one bit wider so the sum cannot wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      period <= '0;
    end else if (int'(sel) < CH) begin
      period <= {1'b0, res_p[sel]} + {1'b0, res_m[sel]};
    end else begin
      period <= '0;
    end
  end
`endif

endmodule

// File: doc/pwm_meter.md
# pwm_meter

Multi-channel pulse-width meter. Measures the high (count_p) and low (count_m) phase durations of CH asynchronous `cnt` inputs in prescaled clock ticks, one measurement engine per channel. Captured values are presented through a registered channel-select readout with per-channel sticky ready flags. It replaces the fixed two-channel, 24-bit, dual-clock counter-plus-mux arrangement in the front-end measurement path.

## Interface
- CH, 2: number of measured channels (1..16).
- WIDTH, 24: accumulator and result width.
- PRESCALE, 3: clk cycles per count tick (1..256); 3 at 12 MHz gives 4 MHz ticks.
- SYNC_STAGES, 2: input synchroniser depth (2..4).

- clk  in  1  system clock (12 MHz nominal); one clock, all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cnt  in  CH  asynchronous measured signals, one bit per channel.
- en  in  CH  per-channel measurement enable.
- sel  in  max(1,$clog2(CH))  readout channel select.
- ack  in  CH  per-channel ready clear, one-cycle pulse.
- count_p  out  WIDTH  high-phase length of the selected channel, in ticks.
- count_m  out  WIDTH  low-phase length of the selected channel, in ticks.
- ovf  out  1  set if either displayed value saturated.
- rdy  out  CH  sticky per-channel new-period flags.
- period  out  WIDTH+1  count_p+count_m of the selected channel; present only with PWM_PERIOD_EN.

## Operation
- Reset value 0 on all outputs, synchronisers, accumulators and the prescaler. All channel FSMs reset to IDLE.
- Prescaler: a single shared counter runs 0..PRESCALE-1 and asserts `tick` when it equals PRESCALE-1. It runs regardless of `en`.
- Each channel synchronises `cnt` through SYNC_STAGES flops, then one history flop. A rise or fall is detected from the synchronised level.
- Per-channel FSM:
  - IDLE: accumulators held at 0. On en=1 go to ARM.
  - ARM: wait for a rising edge; no capture. On the rise, clear p_acc and go to HIGH.
  - HIGH: p_acc increments on `tick`. On a fall: res_p <= p_acc, res_ovf_p <= sat_p, m_acc <= 0, go to LOW.
  - LOW: m_acc increments on `tick`. On a rise: res_m <= m_acc, res_ovf_m <= sat_m, p_acc <= 0, rdy set, go to HIGH.
  - Any state with en=0: go to IDLE next cycle and clear accumulators. res_* and rdy hold.
- Saturating arithmetic: an accumulator at all-ones stays there and its sat flag sets. The sat flag clears together with the accumulator.
- Edge and tick in the same cycle:
  - The capture takes the pre-increment value.
  - The newly cleared accumulator of the entered phase takes the tick, so it holds 1.
- rdy: set has priority over `ack` in the same cycle. `ack` to a channel with rdy=0 has no effect.
- Readout: count_p, count_m and ovf are registered from channel `sel`. ovf = res_ovf_p | res_ovf_m.

## Timing
- A `cnt` transition sampled at edge k is detected combinationally between edges k+SYNC_STAGES-1 and k+SYNC_STAGES.
- The capture and rdy are visible after edge k+SYNC_STAGES.
- Readout outputs lag the internal results and `sel` by 1 cycle.
- Pulses shorter than one clk period may be missed. Phases shorter than PRESCALE cycles can measure 0.
- Reset asserted mid-measurement takes effect at the next edge. No partial result is captured.

## Configuration
- PWM_PERIOD_EN defined: the `period` port exists, registered with the same 1-cycle latency. Its width is WIDTH+1, so the sum never wraps.
- PWM_PERIOD_EN undefined: no `period` port and no adder is synthesised.

## Structure
- Package pwm_meter_pkg holds:
  - the FSM state encoding (IDLE, ARM, HIGH, LOW);
  - the PRESCALE counter width function;
  - the saturating-increment function.
- Sub-module pwm_channel contains the synchroniser, FSM, accumulators, result registers and rdy for one channel. It is instantiated CH times under a generate loop. The prescaler, readout mux and period adder stay in the top level.

## Test plan
- PRESCALE=3, ch0 en=1, cnt0 high 30 clk / low 60 clk repeated -> after the second rise: rdy[0]=1, count_p=10, count_m=20, ovf=0.
- Same stimulus with the first rise arriving during ARM -> no rdy until one full high+low period has completed; the first partial phase is never reported.
- WIDTH=4, cnt0 high 60 clk, low 9 clk -> count_p=15, ovf=1, count_m=3; the next normal period gives ovf=0.
- rdy[1] set and ack[1] pulsed in the same cycle as a new ch1 capture -> rdy[1] stays 1. A later ack alone -> rdy[1]=0 the next cycle.
- en0 dropped mid-HIGH, then raised -> previous results held, rdy unchanged, FSM re-ARMs. Reset mid-LOW -> all outputs 0 after the edge.
- PWM_PERIOD_EN, CH=4, sel toggled 0->3 with ch3 at 12/18 ticks -> period=30 exactly one cycle after the sel change.
